// File: rtl/dct_pkg.sv
// Shared definitions for the first-stage DCT butterfly scheduler.
package dct_pkg;

    // Controller states: load samples, run the butterfly ops, hand results out.
    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN
    } state_t;

    // Number of add/sub ops in one pass (4 pairs x sum/difference).
    localparam int unsigned NUM_OPS = 8;

    // Butterfly pair table indexed by pair p: (A, B) = (0,7), (4,1), (6,2), (5,3).
    // Packed with element 0 in the least-significant slot.
    localparam logic [3:0][2:0] PAIR_A = {3'd5, 3'd6, 3'd4, 3'd0};
    localparam logic [3:0][2:0] PAIR_B = {3'd3, 3'd2, 3'd1, 3'd7};

endpackage

// File: rtl/bfly_addsub.sv
// Combinational signed adder/subtractor shared by all butterfly ops.
module bfly_addsub #(
    parameter int unsigned W = 17
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                addOrSub,
    output logic signed [W-1:0] result
);

    // 0 selects A+B, 1 selects A-B; operands are pre-extended so no overflow.
    always_comb begin
        result = addOrSub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/dct_bfly_sched.sv
// First-stage 8-point DCT butterfly scheduler: one shared add/sub, 8 ops per pass,
// results drained in index order over a valid/ready handshake.
module dct_bfly_sched
    import dct_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [2:0]   add,
    input  logic [N-1:0] data_in,
    input  logic         start,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_idx,
    output logic [N:0]   data_out,
    output logic         done
);

    state_t       state_q, state_d;
    logic [2:0]   op_q;
    logic [2:0]   drain_q;
    logic         done_q;
    logic [N-1:0] samples [8];
    logic [N:0]   results [8];

    logic [2:0]   idx_a, idx_b;
    logic [N:0]   op_a, op_b, op_res;
    logic         last_op, last_accept;

    // Operand selection driven by the op counter; k[0] picks subtraction.
    always_comb begin
        idx_a   = PAIR_A[op_q[2:1]];
        idx_b   = PAIR_B[op_q[2:1]];
        op_a    = {samples[idx_a][N-1], samples[idx_a]};
        op_b    = {samples[idx_b][N-1], samples[idx_b]};
        last_op = (op_q == 3'(NUM_OPS - 1));
        last_accept = (state_q == DRAIN) && out_ready && (drain_q == 3'(NUM_OPS - 1));
    end

    bfly_addsub #(
        .W (N + 1)
    ) u_addsub (
        .a        (op_a),
        .b        (op_b),
        .addOrSub (op_q[0]),
        .result   (op_res)
    );

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: if (last_op) state_d = DRAIN;
            DRAIN:   if (last_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Sample file: writes only land while idle, so a running pass is never disturbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_OPS); i++) samples[i] <= '0;
        end else if (wr && (state_q == IDLE)) begin
            samples[add] <= data_in;
        end
    end

    // Result file and op counter; the counter wraps back to 0 after the last op.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_OPS); i++) results[i] <= '0;
            op_q <= '0;
        end else if (state_q == COMPUTE) begin
            results[op_q] <= op_res;
            op_q          <= op_q + 3'd1;
        end
    end

    // Drain counter advances on each accepted word and wraps to 0 after index 7.
    always_ff @(posedge clk) begin
        if (reset)                              drain_q <= '0;
        else if ((state_q == DRAIN) && out_ready) drain_q <= drain_q + 3'd1;
    end

    // Done pulses in the first idle cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= last_accept;
    end

    // Output decode; data_out is forced to zero outside DRAIN.
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == DRAIN);
        out_idx   = drain_q;
        data_out  = (state_q == DRAIN) ? results[drain_q] : '0;
        done      = done_q;
    end

endmodule

// File: doc/dct_bfly_sched.md
DCT_BFLY_SCHED -- requirements
Module: dct_bfly_sched

Interface
REQ-001 Parameter N, default 16, width of each signed input sample.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr  input  1  write strobe; data_in stored at sample slot add.
REQ-005 add  input  3  sample slot index, 0..7.
REQ-006 data_in  input  N  signed sample.
REQ-007 start  input  1  request to run one first-stage butterfly pass.
REQ-008 busy  output  1  high while computing or draining.
REQ-009 out_valid  output  1  result word available.
REQ-010 out_ready  input  1  consumer accepts the result word when high with out_valid.
REQ-011 out_idx  output  3  index k (0..7) of the presented result.
REQ-012 data_out  output  N+1  signed result word.
REQ-013 done  output  1  one-cycle pulse after the last result is accepted.

Function
REQ-014 The block SHALL hold an 8-entry N-bit sample file; a write SHALL occur only when wr=1 and state=IDLE.
REQ-015 States SHALL be IDLE, COMPUTE and DRAIN.
REQ-016 IDLE->COMPUTE SHALL occur on start=1; start SHALL be ignored outside IDLE.
REQ-017 If wr and start are both high in one IDLE cycle, the write SHALL land first, and the pass SHALL use the new value.
REQ-018 COMPUTE SHALL run exactly 8 cycles using op counter k=0..7, one add/sub per cycle on a single shared adder/subtractor.
REQ-019 Op k SHALL use pair p=k>>1 and SHALL subtract when k[0]=1; pairs are p0=(x0,x7), p1=(x4,x1), p2=(x6,x2), p3=(x5,x3), and each op computes A+B or A-B.
REQ-020 Arithmetic SHALL be exact: operands sign-extended to N+1 bits, no saturation, no overflow possible.
REQ-021 Each result k SHALL be written to an 8-entry (N+1)-bit result file at index k.
REQ-022 COMPUTE->DRAIN SHALL occur after k=7.
REQ-023 In DRAIN the block SHALL present results in index order 0..7 with out_valid=1.
REQ-024 data_out and out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 On each handshake (out_valid & out_ready) the index SHALL advance; after index 7 is accepted the state SHALL return to IDLE.
REQ-026 done SHALL pulse in the first IDLE cycle after DRAIN completes.
REQ-027 Latency: start accepted at edge t, then busy=1 from t+1, COMPUTE spans cycles t+1..t+8, and first out_valid=1 at t+9.
REQ-028 With out_ready held high, the pass SHALL take 17 cycles from start to done.
REQ-029 busy SHALL be 1 in COMPUTE and DRAIN and 0 in IDLE; out_valid SHALL be 0 outside DRAIN.
REQ-030 The sample file SHALL be read only during COMPUTE; writes attempted while busy SHALL be dropped and SHALL NOT corrupt the pass.

Reset
REQ-031 Reset SHALL put the block in IDLE and clear all 8 sample entries, all 8 result entries, and the op and drain counters.
REQ-032 After reset: busy=0, out_valid=0, done=0, out_idx=0, data_out=0.
REQ-033 Reset asserted mid-COMPUTE or mid-DRAIN SHALL abort the pass immediately, with no done pulse and no further out_valid.
REQ-034 Reset SHALL take priority over wr and start in the same cycle.

Structure
REQ-035 A shared package dct_pkg SHALL hold: the state enum (IDLE, COMPUTE, DRAIN), the pair-index table (0/7, 4/1, 6/2, 5/3), and the constant NUM_OPS=8.
REQ-036 One sub-module, bfly_addsub (N+1-bit signed add/sub, combinational, with an addOrSub select where 0=add and 1=sub), SHALL be instantiated exactly once.
REQ-037 The op counter SHALL drive bfly_addsub's operand muxes and addOrSub select.

Verification
REQ-038 Write x0..x7 = 1,2,3,4,5,6,7,8, start, out_ready=1 -> results k0..k7 = 9,-7,7,3,10,4,10,2; done at t+17.
REQ-039 N=16, x0=32767, x7=-32768 -> k0=-1 and k1=65535 (17-bit), with no wrap.
REQ-040 Hold out_ready=0 for 5 cycles at k=3 -> data_out=3 and out_idx=3 are held; order is preserved after release.
REQ-041 Assert start and wr (add=7, data=100) in the same IDLE cycle -> k0=x0+100; start during DRAIN is ignored and no second pass runs.
REQ-042 Assert reset at cycle t+4 of COMPUTE -> busy=0 at the next edge; no out_valid, no done, and the sample file reads zero afterwards.
REQ-043 wr during COMPUTE (add=0, data=50) -> the write is dropped; results match the pre-start samples and a later pass still sees the old x0.
